bk_add_sequencer: RTL and testbench



---
 rtl/bk_add_sequencer.sv | 131 +++++++++++++
 tb/tb_bk_add_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bk_add_sequencer.sv
// Valid/ready sequencer around an external 12-bit Brent-Kung adder: operand FIFO,
// interleaved operand register (S1), result register (S2), accumulate mode, carry counter.
module bk_add_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_a,
    input  logic [11:0]      in_b,
    input  logic             in_acc,
    output logic [23:0]      add_in,
    input  logic [12:0]      add_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [12:0]      out_sum,
    output logic [CNT_W-1:0] carry_cnt
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] CntFull = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [11:0]      fifo_a_q   [FIFO_DEPTH];
    logic [11:0]      fifo_b_q   [FIFO_DEPTH];
    logic             fifo_acc_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q, count_d;

    logic             s1_v_q, s1_v_d;
    logic [23:0]      add_in_q, add_in_d;
    logic             out_valid_q, out_valid_d;
    logic [12:0]      out_sum_q;
    logic [11:0]      acc_reg_q;
    logic [CNT_W-1:0] carry_cnt_q;

    logic        push, pop, fifo_empty, hazard, s2_adv, s1_free;
    logic [11:0] head_a, head_b, b_sel;
    logic        head_acc;

    assign in_ready   = (count_q != CntFull);
    assign fifo_empty = (count_q == '0);
    assign push       = in_valid && in_ready;

    assign head_a   = fifo_a_q[rd_ptr_q];
    assign head_b   = fifo_b_q[rd_ptr_q];
    assign head_acc = fifo_acc_q[rd_ptr_q];

    // An accumulate op must not read acc_reg until the op ahead of it has produced its sum.
    assign hazard  = head_acc && s1_v_q;
    assign s2_adv  = s1_v_q && (!out_valid_q || out_ready);
    assign s1_free = !s1_v_q || s2_adv;
    assign pop     = !fifo_empty && s1_free && !hazard;
    assign b_sel   = head_acc ? acc_reg_q : head_b;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        add_in_d = add_in_q;
        s1_v_d   = s1_v_q;
        if (pop) begin
            for (int i = 0; i < 12; i++) begin
                add_in_d[2*i]   = head_a[i];
                add_in_d[2*i+1] = b_sel[i];
            end
            s1_v_d = 1'b1;
        end else if (s2_adv) begin
            s1_v_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (s2_adv) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // FIFO storage carries no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q]   <= in_a;
            fifo_b_q[wr_ptr_q]   <= in_b;
            fifo_acc_q[wr_ptr_q] <= in_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            s1_v_q      <= 1'b0;
            add_in_q    <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            acc_reg_q   <= '0;
            carry_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            s1_v_q      <= s1_v_d;
            add_in_q    <= add_in_d;
            out_valid_q <= out_valid_d;
            if (s2_adv) begin
                out_sum_q <= add_out;
                acc_reg_q <= add_out[11:0];
                if (add_out[12] && carry_cnt_q != CntMax) begin
                    carry_cnt_q <= carry_cnt_q + 1'b1;
                end
            end
        end
    end

    assign add_in    = add_in_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_bk_add_sequencer.sv
// Scoreboard bench for bk_add_sequencer; models the external adder from add_in.
module tb_bk_add_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_a, in_b;
    logic        in_acc;
    logic [23:0] add_in;
    logic [12:0] add_out;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_sum;
    logic [7:0]  carry_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [12:0] exp_q[$];

    always #5 clk = ~clk;

    bk_add_sequencer #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_acc    (in_acc),
        .add_in    (add_in),
        .add_out   (add_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .carry_cnt (carry_cnt)
    );

    // External adder: de-interleave and add.
    logic [11:0] adder_a, adder_b;
    always_comb begin
        adder_a = '0;
        adder_b = '0;
        for (int i = 0; i < 12; i++) begin
            adder_a[i] = add_in[2*i];
            adder_b[i] = add_in[2*i+1];
        end
    end
    assign add_out = {1'b0, adder_a} + {1'b0, adder_b};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every output handshake is compared with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {19'd0, out_sum}, 32'hDEAD);
                end else begin
                    check("out_sum", {19'd0, out_sum}, {19'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [11:0] a, input logic [11:0] b, input logic acc,
                           input logic [12:0] exp);
        bit ok = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_acc   = acc;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        if (ok) exp_q.push_back(exp);
        else check("push_timeout", 32'd0, 32'd1);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        int k;
        bit acc_now;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_acc = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {19'd0, out_sum}, 32'd0);
        check("rst_add_in", {8'd0, add_in}, 32'd0);
        check("rst_carry_cnt", {24'd0, carry_cnt}, 32'd0);

        // Carry out with latency
        push_op(12'hFFF, 12'h001, 1'b0, 13'h1000);
        tick();
        check("carry_add_in", {8'd0, add_in}, 32'h555557);
        tick();
        check("carry_out_valid", {31'd0, out_valid}, 32'd1);
        check("carry_out_sum", {19'd0, out_sum}, 32'h1000);
        check("carry_cnt1", {24'd0, carry_cnt}, 32'd1);
        wait_drain();

        // Bit interleaving
        push_op(12'hAAA, 12'h000, 1'b0, 13'h0AAA);
        tick();
        check("ilv_add_in_a", {8'd0, add_in}, 32'h444444);
        wait_drain();
        push_op(12'h000, 12'hFFF, 1'b0, 13'h0FFF);
        tick();
        check("ilv_add_in_b", {8'd0, add_in}, 32'hAAAAAA);
        wait_drain();

        // Backpressure: 8 offered, 6 fit
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 14; c++) begin
            in_valid = (k < 8);
            in_a     = 12'(k);
            in_b     = '0;
            in_acc   = 1'b0;
            @(negedge clk);
            acc_now = in_valid && in_ready;
            @(posedge clk);
            if (acc_now) begin
                exp_q.push_back(13'(k));
                k++;
            end
            #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", k, 32'd6);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        wait_drain();
        check("bp_in_ready_high", {31'd0, in_ready}, 32'd1);

        // Accumulate chain from reset, one bubble between dependent ops
        do_reset();
        push_op(12'h005, 12'h000, 1'b1, 13'h0005);
        push_op(12'h007, 12'h000, 1'b1, 13'h000C);
        push_op(12'hFFC, 12'h000, 1'b1, 13'h1008);
        check("acc_v0", {31'd0, out_valid}, 32'd1);
        tick(); check("acc_v1", {31'd0, out_valid}, 32'd0);
        tick(); check("acc_v2", {31'd0, out_valid}, 32'd1);
        tick(); check("acc_v3", {31'd0, out_valid}, 32'd0);
        tick(); check("acc_v4", {31'd0, out_valid}, 32'd1);
        wait_drain();
        check("acc_carry_cnt", {24'd0, carry_cnt}, 32'd1);

        // Reset mid-operation
        out_ready = 1'b0;
        push_op(12'h100, 12'h001, 1'b0, 13'h0101);
        push_op(12'h200, 12'h002, 1'b0, 13'h0202);
        push_op(12'h300, 12'h003, 1'b0, 13'h0303);
        do_reset();
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_carry_cnt", {24'd0, carry_cnt}, 32'd0);
        out_ready = 1'b1;
        push_op(12'h001, 12'h001, 1'b0, 13'h0002);
        tick();
        tick();
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_out_sum", {19'd0, out_sum}, 32'h0002);
        wait_drain();

        // Saturation
        for (int i = 0; i < 260; i++) begin
            push_op(12'h800, 12'h800, 1'b0, 13'h1000);
        end
        wait_drain();
        check("sat_carry_cnt", {24'd0, carry_cnt}, 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
